// File: rtl/counter_mod_updown.sv
// Parametrised up/down modulo counter with clock enable, synchronous load,
// combinational terminal count and a sticky wrap flag.
module counter_mod_updown #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] O,
    output logic             TC,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    if (WIDTH < 1) begin : g_bad_width
        $error("counter_mod_updown: WIDTH must be at least 1");
    end
    if (MAX == ZERO) begin : g_bad_max
        $error("counter_mod_updown: MAX must be non-zero");
    end
    if (INIT > MAX) begin : g_bad_init
        $error("counter_mod_updown: INIT must not exceed MAX");
    end

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_sat;
    logic             tc_int;

    assign at_max   = (count_reg == MAX);
    assign at_zero  = (count_reg == ZERO);
    assign load_sat = (LOAD_VAL > MAX) ? MAX : LOAD_VAL;

    // TC flags the cycle whose edge will wrap; a load in the same cycle masks it.
    assign tc_int = CE & ~LOAD & (UP ? at_max : at_zero);

    always_comb begin
        count_next = count_reg;
        if (LOAD) begin
            count_next = load_sat;
        end else if (CE) begin
            if (UP) begin
                count_next = at_max ? ZERO : (count_reg + ONE);
            end else begin
                count_next = at_zero ? MAX : (count_reg - ONE);
            end
        end
    end

    // A wrap in the same cycle as a clear request keeps the flag set.
    assign ovf_next = tc_int | (ovf_reg & ~CLR_OVF);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_reg <= INIT;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign O   = count_reg;
    assign TC  = tc_int;
    assign OVF = ovf_reg;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Scoreboard bench for counter_mod_updown: directed vectors push the expected
// per-cycle state, a negedge monitor pops and compares.
module tb_counter_mod_updown;

    typedef struct {
        logic [3:0] o;
        logic       tc;
        logic       ovf;
        string      name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       clr_ovf;
    logic [3:0] o;
    logic       tc;
    logic       ovf;

    logic       reset8;
    logic       ce8;
    logic [7:0] o8;
    logic       tc8;
    logic       ovf8;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    counter_mod_updown #(.WIDTH(4), .MAX(4'd9), .INIT(4'd3)) dut (
        .CLK      (clk),
        .RESET    (reset),
        .CE       (ce),
        .UP       (up),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .CLR_OVF  (clr_ovf),
        .O        (o),
        .TC       (tc),
        .OVF      (ovf)
    );

    counter_mod_updown #(.WIDTH(8)) dut8 (
        .CLK      (clk),
        .RESET    (reset8),
        .CE       (ce8),
        .UP       (1'b1),
        .LOAD     (1'b0),
        .LOAD_VAL (8'd0),
        .CLR_OVF  (1'b0),
        .O        (o8),
        .TC       (tc8),
        .OVF      (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: the counter presents a new state every cycle, so one entry per negedge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".O"},   int'(o),   int'(e.o));
            check({e.name, ".TC"},  int'(tc),  int'(e.tc));
            check({e.name, ".OVF"}, int'(ovf), int'(e.ovf));
            $display("cycle %0d %s: O=%0d TC=%0d OVF=%0d (exp %0d/%0d/%0d)",
                     cyc_no, e.name, o, tc, ovf, e.o, e.tc, e.ovf);
            cyc_no++;
        end
    end

    // Drive one cycle of inputs just after the edge and record the state
    // expected during that cycle (O/OVF from previous edges, TC from these inputs).
    task automatic cyc(input logic rst, input logic c, input logic u,
                       input logic ld, input logic [3:0] lv, input logic clr,
                       input logic [3:0] eo, input logic etc, input logic eovf,
                       input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        ce       = c;
        up       = u;
        load     = ld;
        load_val = lv;
        clr_ovf  = clr;
        e.o = eo; e.tc = etc; e.ovf = eovf; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        int tc_cnt;
        int tc_at;
        reset = 1'b0; ce = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
        reset8 = 1'b0; ce8 = 1'b0;
        tc_cnt = 0; tc_at = -1;

        //   rst ce up ld lv  clr  O  TC OVF
        cyc(0, 1, 1, 0, 0,  0,  3, 0, 0, "reset_hold_ce");
        cyc(0, 1, 1, 0, 0,  0,  3, 0, 0, "reset_hold_ce2");
        cyc(1, 1, 1, 0, 0,  0,  3, 0, 0, "reset_release");
        cyc(1, 1, 1, 0, 0,  0,  4, 0, 0, "up4");
        cyc(1, 1, 1, 0, 0,  0,  5, 0, 0, "up5");
        cyc(1, 1, 1, 0, 0,  0,  6, 0, 0, "up6");
        cyc(1, 1, 1, 0, 0,  0,  7, 0, 0, "up7");
        cyc(1, 1, 1, 0, 0,  0,  8, 0, 0, "up8");
        cyc(1, 1, 1, 0, 0,  0,  9, 1, 0, "up9_tc");
        cyc(1, 1, 1, 0, 0,  0,  0, 0, 1, "up_wrap0");
        cyc(1, 0, 1, 1, 1,  0,  1, 0, 1, "up1_load1");
        cyc(1, 1, 0, 0, 0,  0,  1, 0, 1, "down_from1");
        cyc(1, 1, 0, 0, 0,  1,  0, 1, 1, "down0_clr_race");
        cyc(1, 0, 0, 0, 0,  1,  9, 0, 1, "down_wrap9_clr");
        cyc(1, 0, 0, 0, 0,  0,  9, 0, 0, "ovf_cleared");
        cyc(1, 1, 1, 1, 6,  0,  9, 0, 0, "load_at_max_tc0");
        cyc(1, 1, 1, 1, 14, 0,  6, 0, 0, "load6_priority");
        cyc(1, 0, 1, 1, 5,  0,  9, 0, 0, "load14_saturate");
        cyc(1, 0, 1, 0, 0,  0,  5, 0, 0, "hold5_a");
        cyc(1, 0, 1, 0, 0,  0,  5, 0, 0, "hold5_b");
        cyc(1, 0, 1, 0, 0,  0,  5, 0, 0, "hold5_c");
        cyc(1, 1, 1, 0, 0,  0,  5, 0, 0, "dir_up");
        cyc(1, 1, 0, 0, 0,  0,  6, 0, 0, "dir_down");
        cyc(1, 1, 1, 0, 0,  0,  5, 0, 0, "dir_up2");
        cyc(1, 1, 0, 0, 0,  0,  6, 0, 0, "dir_down2");
        cyc(1, 0, 1, 1, 9,  0,  5, 0, 0, "dir_end_load9");
        cyc(1, 1, 1, 0, 0,  0,  9, 1, 0, "pre_wrap");
        cyc(1, 1, 1, 0, 0,  0,  0, 0, 1, "wrapped");
        cyc(0, 1, 1, 1, 8,  0,  3, 0, 0, "async_reset_mid");
        cyc(1, 0, 1, 0, 0,  0,  3, 0, 0, "after_reset");

        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        // Full-range default modulus on the 8-bit instance.
        @(posedge clk);
        #1;
        reset8 = 1'b1;
        ce8    = 1'b1;
        repeat (256) begin
            @(negedge clk);
            if (tc8) begin
                tc_cnt++;
                tc_at = int'(o8);
            end
            @(posedge clk);
        end
        #1;
        ce8 = 1'b0;
        @(negedge clk);
        check("full_range.O",      int'(o8),   0);
        check("full_range.OVF",    int'(ovf8), 1);
        check("full_range.TC_cnt", tc_cnt,     1);
        check("full_range.TC_at",  tc_at,      255);
        check("full_range.TC_off", int'(tc8),  0);
        $display("full_range: O=%0d OVF=%0d tc_pulses=%0d tc_at=%0d", o8, ovf8, tc_cnt, tc_at);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
